ps2_cmd_ctrl: RTL and testbench
===============================

PS2_CMD_CTRL -- requirements
Module: ps2_cmd_ctrl

Interface
REQ-001 Parameter: TX_TIMEOUT, 2_500_000, maximum cycles from tx_wr to tx_done_tick (50 ms @ 50 MHz).
REQ-002 Parameter: ACK_TIMEOUT, 1_000_000, maximum cycles from tx_done_tick to a device response (20 ms @ 50 MHz).
REQ-003 Parameter: MAX_RETRY, 3, number of resends allowed after 0xFE responses.
REQ-004 Port: clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: cmd_valid  in  1  host command request.
REQ-007 Port: cmd_byte  in  8  command byte to send to the device.
REQ-008 Port: cmd_ready  out  1  high only in IDLE; the command is accepted when cmd_valid & cmd_ready.
REQ-009 Port: busy  out  1  equals ~cmd_ready.
REQ-010 Port: tx_wr  out  1  one-cycle write strobe to the PS/2 transmitter.
REQ-011 Port: tx_din  out  8  byte to transmit; holds the latched command byte.
REQ-012 Port: tx_idle  in  1  transmitter idle flag.
REQ-013 Port: tx_done_tick  in  1  transmitter frame-complete pulse.
REQ-014 Port: rx_en  out  1  receiver enable; high in IDLE and WAIT_ACK only.
REQ-015 Port: rx_done_tick  in  1  received-byte pulse.
REQ-016 Port: rx_dout  in  8  received byte, valid with rx_done_tick.
REQ-017 Port: rsp_done_tick  out  1  one-cycle pulse marking command completion.
REQ-018 Port: rsp_code  out  2  result: 00 ack, 01 NAK/error, 10 transmit timeout, 11 ack timeout.

Function
REQ-019 The state machine SHALL have the states IDLE, SEND, WAIT_TX, WAIT_ACK and DONE.
REQ-020 In IDLE, on accept, the block SHALL latch cmd_byte into tx_din, clear the retry counter and go to SEND.
REQ-021 SEND SHALL wait while tx_idle=0; when tx_idle=1 it SHALL assert tx_wr for exactly one cycle, load the timer with TX_TIMEOUT-1 and go to WAIT_TX.
REQ-022 Latency: when tx_idle=1, tx_wr SHALL be asserted exactly 1 cycle after the accept cycle.
REQ-023 WAIT_TX: on tx_done_tick the block SHALL load the timer with ACK_TIMEOUT-1 and go to WAIT_ACK.
REQ-024 WAIT_TX: if the timer equals 0 and there is no tx_done_tick, the block SHALL set result 10 and go to DONE; otherwise the timer decrements by 1 per cycle.
REQ-025 WAIT_ACK: rx_done_tick with rx_dout=0xFA SHALL give result 00 and go to DONE.
REQ-026 WAIT_ACK: rx_done_tick with rx_dout=0xFE and retry count < MAX_RETRY SHALL increment the retry count and go to SEND, resending the same byte.
REQ-027 WAIT_ACK: rx_done_tick with 0xFE and retry count = MAX_RETRY, or with 0xFC, SHALL give result 01 and go to DONE.
REQ-028 WAIT_ACK: any other received byte SHALL be ignored; the timer continues.
REQ-029 WAIT_ACK: if the timer equals 0 with no rx_done_tick, the block SHALL give result 11 and go to DONE.
REQ-030 Simultaneous events: a received byte or tx_done_tick in the timer-zero cycle SHALL take priority over the timeout.
REQ-031 DONE SHALL last exactly one cycle, with rsp_done_tick=1 and rsp_code updated in that same cycle, then return to IDLE.
REQ-032 rsp_code SHALL hold its value until the next rsp_done_tick.
REQ-033 rx_done_tick SHALL be ignored outside WAIT_ACK.
REQ-034 tx_done_tick SHALL be ignored outside WAIT_TX.
REQ-035 cmd_valid SHALL be ignored while busy; no queueing.
REQ-036 Timer width SHALL be ceil(log2(max(TX_TIMEOUT, ACK_TIMEOUT))) bits.
REQ-037 The retry counter SHALL be 2 bits, sized for MAX_RETRY ≤ 3.

Reset
REQ-038 reset_n=0 SHALL immediately force IDLE, with timer=0, retry=0, tx_din=0x00, tx_wr=0, rsp_done_tick=0 and rsp_code=00.
REQ-039 Under reset, cmd_ready=1, busy=0 and rx_en=1.
REQ-040 Reset asserted mid-command SHALL abort the command with no rsp_done_tick; tx_wr SHALL NOT be asserted again until a new accept.

Verification
REQ-041 Ack path: cmd 0xF4 with tx_idle=1 -> tx_wr one cycle later with tx_din=0xF4; tx_done_tick, then rx 0xFA -> rsp_done_tick with rsp_code=00; cmd_ready=1 on the next cycle.
REQ-042 Retry path: cmd 0xFF answered by 0xFE three times, then 0xFA -> 4 tx_wr pulses, all with 0xFF, then rsp_code=00; with four 0xFE responses -> rsp_code=01 after 4 tx_wr pulses.
REQ-043 Timeouts (ACK_TIMEOUT=16, TX_TIMEOUT=32): no tx_done_tick -> rsp_done_tick 32 cycles after tx_wr with rsp_code=10; tx_done_tick but no rx byte -> rsp_code=11 16 cycles after tx_done_tick.
REQ-044 Boundary: rx 0xFA coincident with the timer-zero cycle -> rsp_code=00; stray byte 0x55 in WAIT_ACK is ignored and 0xFA afterwards -> rsp_code=00.
REQ-045 Busy and reset: tx_idle=0 holds the block in SEND with no tx_wr; cmd_valid while busy is ignored; reset_n pulsed low in WAIT_ACK -> IDLE, no rsp_done_tick, and a later 0xFA is ignored.

Source files
------------

// File: rtl/ps2_cmd_ctrl_if.sv
// Host command, PS/2 transmitter and PS/2 receiver signals of the command controller.
// The slave modport is the controller; the master modport is the host plus the PS/2 PHY.
interface ps2_cmd_ctrl_if;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       busy;
  logic       tx_wr;
  logic [7:0] tx_din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       rx_en;
  logic       rx_done_tick;
  logic [7:0] rx_dout;
  logic       rsp_done_tick;
  logic [1:0] rsp_code;

  modport slave (
    input  cmd_valid, cmd_byte, tx_idle, tx_done_tick, rx_done_tick, rx_dout,
    output cmd_ready, busy, tx_wr, tx_din, rx_en, rsp_done_tick, rsp_code
  );

  modport master (
    output cmd_valid, cmd_byte, tx_idle, tx_done_tick, rx_done_tick, rx_dout,
    input  cmd_ready, busy, tx_wr, tx_din, rx_en, rsp_done_tick, rsp_code
  );
endinterface

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command controller: sends one command byte, waits for the device
// acknowledge, resends on 0xFE up to MAX_RETRY times and reports a 2-bit result.
module ps2_cmd_ctrl #(
  parameter int TX_TIMEOUT  = 2_500_000,
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY   = 3
) (
  input logic           clk,
  input logic           reset_n,
  ps2_cmd_ctrl_if.slave bus
);

  localparam int TMAX = (TX_TIMEOUT > ACK_TIMEOUT) ? TX_TIMEOUT : ACK_TIMEOUT;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] TX_LOAD  = TW'(TX_TIMEOUT - 1);
  localparam logic [TW-1:0] ACK_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic [1:0]    RETRY_LIMIT = 2'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_ACK, DONE} state_e;
  typedef enum logic [1:0] {RSP_ACK = 2'b00, RSP_ERR = 2'b01,
                            RSP_TX_TO = 2'b10, RSP_ACK_TO = 2'b11} rsp_e;

  state_e        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    retry_q;
  logic [7:0]    tx_din_q;
  rsp_e          rsp_code_q;

  logic rx_ack, rx_nak, rx_err;

  assign rx_ack = bus.rx_done_tick && (bus.rx_dout == 8'hFA);
  assign rx_nak = bus.rx_done_tick && (bus.rx_dout == 8'hFE);
  assign rx_err = bus.rx_done_tick && (bus.rx_dout == 8'hFC);

  assign bus.cmd_ready     = (state_q == IDLE);
  assign bus.busy          = (state_q != IDLE);
  // The strobe is issued in the SEND cycle itself so it lands one cycle after the accept.
  assign bus.tx_wr         = (state_q == SEND) && bus.tx_idle;
  assign bus.tx_din        = tx_din_q;
  assign bus.rx_en         = (state_q == IDLE) || (state_q == WAIT_ACK);
  assign bus.rsp_done_tick = (state_q == DONE);
  assign bus.rsp_code      = rsp_code_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      retry_q    <= '0;
      tx_din_q   <= '0;
      rsp_code_q <= RSP_ACK;
    end else begin
      // NOTE: non-blocking assignments only, so every branch reads the pre-edge state.
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            tx_din_q <= bus.cmd_byte;
            retry_q  <= '0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (bus.tx_idle) begin
            timer_q <= TX_LOAD;
            state_q <= WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (bus.tx_done_tick) begin
            timer_q <= ACK_LOAD;
            state_q <= WAIT_ACK;
          end else if (timer_q == '0) begin
            rsp_code_q <= RSP_TX_TO;
            state_q    <= DONE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        WAIT_ACK: begin
          // Device responses win over a timeout landing in the same cycle.
          if (rx_ack) begin
            rsp_code_q <= RSP_ACK;
            state_q    <= DONE;
          end else if (rx_nak && (retry_q < RETRY_LIMIT)) begin
            retry_q <= retry_q + 2'd1;
            state_q <= SEND;
          end else if (rx_nak || rx_err) begin
            rsp_code_q <= RSP_ERR;
            state_q    <= DONE;
          end else if (timer_q == '0) begin
            rsp_code_q <= RSP_ACK_TO;
            state_q    <= DONE;
          end else begin
            timer_q <= timer_q - TW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl with short timeouts (TX 32, ACK 16 cycles).
module tb_ps2_cmd_ctrl;
  localparam int TX_TO  = 32;
  localparam int ACK_TO = 16;
  localparam int BUDGET = 200;

  logic clk = 1'b0;
  logic reset_n;
  int   vectors     = 0;
  int   miscompares = 0;
  int   n;
  int   wr_pulses;

  ps2_cmd_ctrl_if bus ();

  ps2_cmd_ctrl #(
    .TX_TIMEOUT (TX_TO),
    .ACK_TIMEOUT(ACK_TO),
    .MAX_RETRY  (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = b;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic pulse_tx_done();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    bus.rx_done_tick = 1'b1;
    bus.rx_dout      = b;
    tick();
    bus.rx_done_tick = 1'b0;
    bus.rx_dout      = 8'h00;
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_byte     = 8'h00;
    bus.tx_idle      = 1'b1;
    bus.tx_done_tick = 1'b0;
    bus.rx_done_tick = 1'b0;
    bus.rx_dout      = 8'h00;
    reset_n          = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_en", bus.rx_en, 1);
    check("rst_tx_wr", bus.tx_wr, 0);
    check("rst_done", bus.rsp_done_tick, 0);
    check("rst_code", bus.rsp_code, 2'b00);
    check("rst_tx_din", bus.tx_din, 8'h00);
    reset_n = 1'b1;
    tick();

    // Ack path
    send_cmd(8'hF4);
    check("ack_tx_wr", bus.tx_wr, 1);
    check("ack_tx_din", bus.tx_din, 8'hF4);
    check("ack_busy", bus.busy, 1);
    check("ack_rx_en_send", bus.rx_en, 0);
    tick();
    check("ack_tx_wr_once", bus.tx_wr, 0);
    pulse_tx_done();
    check("ack_rx_en_wait", bus.rx_en, 1);
    pulse_rx(8'hFA);
    check("ack_done", bus.rsp_done_tick, 1);
    check("ack_code", bus.rsp_code, 2'b00);
    tick();
    check("ack_ready_after", bus.cmd_ready, 1);
    check("ack_done_one_cycle", bus.rsp_done_tick, 0);

    // Retry path: three NAKs then ACK
    wr_pulses = 0;
    send_cmd(8'hFF);
    if (bus.tx_wr) wr_pulses++;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulse_tx_done();
      pulse_rx(8'hFE);
      check("retry_resend_wr", bus.tx_wr, 1);
      check("retry_resend_din", bus.tx_din, 8'hFF);
      if (bus.tx_wr) wr_pulses++;
    end
    tick();
    pulse_tx_done();
    pulse_rx(8'hFA);
    check("retry_done", bus.rsp_done_tick, 1);
    check("retry_code", bus.rsp_code, 2'b00);
    check("retry_wr_pulses", wr_pulses, 4);
    tick();

    // Retry exhausted: four NAKs
    wr_pulses = 0;
    send_cmd(8'hFF);
    if (bus.tx_wr) wr_pulses++;
    for (int i = 0; i < 4; i++) begin
      tick();
      pulse_tx_done();
      pulse_rx(8'hFE);
      if (bus.tx_wr) wr_pulses++;
    end
    check("nak4_done", bus.rsp_done_tick, 1);
    check("nak4_code", bus.rsp_code, 2'b01);
    check("nak4_wr_pulses", wr_pulses, 4);
    tick();

    // Transmit timeout: WAIT_TX lasts TX_TO cycles after tx_wr
    send_cmd(8'hED);
    tick();
    check("txto_code_held", bus.rsp_code, 2'b01);
    n = 0;
    while (!bus.rsp_done_tick && n < BUDGET) begin
      n++;
      tick();
    end
    check("txto_cycles", n, TX_TO);
    check("txto_code", bus.rsp_code, 2'b10);
    tick();

    // Ack timeout: WAIT_ACK lasts ACK_TO cycles after tx_done_tick
    send_cmd(8'hF2);
    tick();
    pulse_tx_done();
    n = 0;
    while (!bus.rsp_done_tick && n < BUDGET) begin
      n++;
      tick();
    end
    check("ackto_cycles", n, ACK_TO);
    check("ackto_code", bus.rsp_code, 2'b11);
    tick();

    // tx_done_tick in the timer-zero cycle of WAIT_TX, then ACK in the timer-zero cycle of WAIT_ACK
    send_cmd(8'hF3);
    repeat (TX_TO) tick();
    pulse_tx_done();
    check("edge_tx_no_timeout", bus.rsp_done_tick, 0);
    check("edge_tx_wait_ack", bus.rx_en, 1);
    repeat (ACK_TO - 1) tick();
    pulse_rx(8'hFA);
    check("edge_ack_done", bus.rsp_done_tick, 1);
    check("edge_ack_code", bus.rsp_code, 2'b00);
    tick();

    // 0xFC is an error response
    send_cmd(8'hF0);
    tick();
    pulse_tx_done();
    pulse_rx(8'hFC);
    check("fc_code", bus.rsp_code, 2'b01);
    tick();

    // Stray byte ignored, then ACK
    send_cmd(8'hF5);
    tick();
    pulse_tx_done();
    pulse_rx(8'h55);
    check("stray_no_done", bus.rsp_done_tick, 0);
    check("stray_still_wait", bus.rx_en, 1);
    pulse_rx(8'hFA);
    check("stray_done", bus.rsp_done_tick, 1);
    check("stray_code", bus.rsp_code, 2'b00);
    tick();

    // Transmitter busy holds SEND; commands while busy and rx outside WAIT_ACK are ignored
    bus.tx_idle = 1'b0;
    send_cmd(8'hAA);
    check("hold_no_wr", bus.tx_wr, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_byte  = 8'h55;
    repeat (3) tick();
    bus.cmd_valid = 1'b0;
    check("hold_still_no_wr", bus.tx_wr, 0);
    check("hold_busy", bus.busy, 1);
    bus.tx_idle = 1'b1;
    #1;
    check("hold_release_wr", bus.tx_wr, 1);
    check("hold_din_kept", bus.tx_din, 8'hAA);
    tick();
    pulse_rx(8'hFA);
    check("rx_in_wait_tx_ignored", bus.rsp_done_tick, 0);
    check("rx_in_wait_tx_busy", bus.busy, 1);

    // Reset pulsed in WAIT_ACK aborts silently
    pulse_tx_done();
    check("abort_in_wait_ack", bus.rx_en, 1);
    reset_n = 1'b0;
    #1;
    check("abort_ready", bus.cmd_ready, 1);
    check("abort_no_done", bus.rsp_done_tick, 0);
    check("abort_tx_din", bus.tx_din, 8'h00);
    tick();
    reset_n = 1'b1;
    tick();
    pulse_rx(8'hFA);
    check("abort_late_ack_done", bus.rsp_done_tick, 0);
    check("abort_late_ack_ready", bus.cmd_ready, 1);
    check("abort_no_wr", bus.tx_wr, 0);
    tick();
    check("abort_idle_no_wr", bus.tx_wr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
